wb_ram_slave: RTL and testbench
===============================

Name: wb_ram_slave

Overview:
- Wishbone B3 classic slave responder: single-port on-chip 32-bit RAM with byte-lane writes and a fixed, parameterised number of wait states.
- Attaches to one slave port of the Wishbone interconnect, alongside the GPIO, UART, flash and SDRAM controllers. Serves as fast scratch or boot memory for the processor's instruction and data masters.
- Answers every cycle started by a master with exactly one single-cycle registered acknowledge.

Parameters:
- ADDR_WIDTH, 12, word-address bits. Depth is 2**ADDR_WIDTH words (default 4096 words = 16 KiB).
- WAIT_STATES, 1, extra cycles inserted between request sampling and ack. Legal range 0..15.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- wb_cyc_i  in  1  bus cycle in progress.
- wb_stb_i  in  1  strobe, valid transfer request.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  32  byte address.
- wb_sel_i  in  4  byte-lane select; sel[0] = bits 7:0 … sel[3] = bits 31:24.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  transfer acknowledge, registered, one-cycle pulse.
- wb_err_o  out  1  error acknowledge. Tied 0 unless WB_RAM_ERR_EN.

Behaviour:
- Clock and reset: one clock (wb_clk_i). Reset is synchronous and active-high (wb_rst_i).
- Reset values: state=IDLE, wb_ack_o=0, wb_err_o=0, wb_dat_o=32'h0, wait counter=0. RAM contents are not cleared.
- Word index = wb_adr_i[ADDR_WIDTH+1:2]. Higher address bits are ignored, so addresses alias modulo the depth. wb_adr_i[1:0] is ignored unless WB_RAM_ERR_EN.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: on a cycle with wb_cyc_i & wb_stb_i, latch index, we, sel and dat_i, and load counter=WAIT_STATES. Go to WAIT if WAIT_STATES>0, else ACK.
  - WAIT: decrement counter each cycle. When counter==1 and wb_cyc_i is still high, go to ACK.
  - ACK: wb_ack_o=1 for exactly this cycle, then unconditionally go to IDLE.
- Latency: request sampled at edge N gives ack high during cycle N+WAIT_STATES+1.
- Throughput: at most one transfer per WAIT_STATES+2 cycles. IDLE re-samples stb on the cycle after ACK, so back-to-back requests with stb held high are served.
- Write commit:
  - Performed at the edge entering ACK, using the latched values.
  - Only lanes with sel=1 are updated; other bytes are unchanged.
  - sel=4'b0000 writes nothing but is still acked.
- Read:
  - At the edge entering ACK, wb_dat_o <= full word at the latched index, regardless of sel.
  - wb_dat_o holds its value outside ACK and is not changed by writes.
- Abort: if wb_cyc_i falls while in WAIT, go to IDLE next edge. No ack, no write, wb_dat_o unchanged.
- Latched request: wb_stb_i, wb_adr_i and wb_dat_i changing during WAIT are ignored.
- Reset mid-transfer: reset wins over any state. No ack, and a pending write is discarded.
- Ack and err are never high in the same cycle.

Optional Feature:
- Macro: WB_RAM_ERR_EN.
- Defined: a request with wb_adr_i[1:0]!=2'b00 or wb_sel_i==4'b0000 follows the same FSM and latency. At the ACK slot it raises wb_err_o for one cycle instead of wb_ack_o. No RAM write; wb_dat_o unchanged.
- Not defined: wb_err_o is constant 0. Such requests are acked normally: low address bits ignored, sel=0 write is a no-op.

Test Plan:
All scenarios use ADDR_WIDTH=12, WAIT_STATES=1.
1. Reset: wb_rst_i high 2 cycles with stb high → wb_ack_o=0, wb_err_o=0, wb_dat_o=0; no ack until 1 cycle after reset release plus latency.
2. Write/read: write 32'hDEADBEEF to 32'h0000_0010 with sel=4'hF, stb sampled at edge N → ack high only in cycle N+2. Read of 32'h10 → ack at N'+2 with wb_dat_o=32'hDEADBEEF.
3. Byte lane: write 32'h0000_5500 to 32'h10 with sel=4'b0010, then read 32'h10 → 32'hDEAD55EF.
4. Abort: start a write of 32'h12345678 to 32'h20 and drop wb_cyc_i one cycle after sampling → no ack. A later read of 32'h20 returns the prior value (32'h0 after a zero-preloaded start).
5. Alias and back-to-back: read 32'h0000_4010 with stb held continuously for two transfers → 32'hDEAD55EF each time. Acks are 3 cycles apart, each exactly one cycle wide.
6. WB_RAM_ERR_EN defined: write to 32'h0000_0011 with sel=4'hF → wb_err_o pulse at N+2, wb_ack_o stays 0; a following read of 32'h10 is still 32'hDEAD55EF. Without the macro, the same access is acked and wb_err_o stays 0.

Source files
------------

// File: rtl/wb_ram_slave.sv
// Wishbone B3 classic single-port 32-bit RAM slave with byte-lane writes and fixed wait states.
// Optional macro WB_RAM_ERR_EN: misaligned or sel==0 requests finish with wb_err_o instead of wb_ack_o.
module wb_ram_slave #(
   parameter int ADDR_WIDTH  = 12,
   parameter int WAIT_STATES = 1
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o
);

   localparam int DEPTH   = 2 ** ADDR_WIDTH;
   localparam bit ZERO_WS = (WAIT_STATES == 0);

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t                state_reg;
   logic [3:0]            cnt_reg;
   logic                  ack_reg;
   logic                  err_reg;
   logic [ADDR_WIDTH-1:0] idx_reg;
   logic                  we_reg;
   logic                  bad_reg;
   logic [3:0]            sel_reg;
   logic [31:0]           dat_reg;

   logic                  req;
   logic                  req_bad;
   logic [ADDR_WIDTH-1:0] req_idx;
   logic [ADDR_WIDTH-1:0] acc_idx;
   logic                  acc_we;
   logic                  acc_bad;
   logic [3:0]            acc_sel;
   logic [31:0]           acc_dat;
   logic                  go_ack;
   logic                  wr_en;
   logic                  rd_en;
   logic                  unused_adr;

   assign req     = wb_cyc_i & wb_stb_i;
   assign req_idx = wb_adr_i[ADDR_WIDTH+1:2];

`ifdef WB_RAM_ERR_EN
   assign req_bad = (wb_adr_i[1:0] != 2'b00) || (wb_sel_i == 4'b0000);
`else
   assign req_bad = 1'b0;
`endif

   // With no wait states the RAM is accessed on the sampling edge itself, so use the live bus.
   assign acc_idx = ZERO_WS ? req_idx  : idx_reg;
   assign acc_we  = ZERO_WS ? wb_we_i  : we_reg;
   assign acc_bad = ZERO_WS ? req_bad  : bad_reg;
   assign acc_sel = ZERO_WS ? wb_sel_i : sel_reg;
   assign acc_dat = ZERO_WS ? wb_dat_i : dat_reg;

   assign go_ack = ((state_reg == IDLE) && req && ZERO_WS) ||
                   ((state_reg == WAIT) && wb_cyc_i && (cnt_reg == 4'd1));
   assign wr_en  = go_ack & acc_we & ~acc_bad & ~wb_rst_i;
   assign rd_en  = go_ack & ~acc_we & ~acc_bad;

   assign unused_adr = &{1'b0, wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         ack_reg   <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         ack_reg <= 1'b0;
         err_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req) begin
                  idx_reg <= req_idx;
                  we_reg  <= wb_we_i;
                  bad_reg <= req_bad;
                  sel_reg <= wb_sel_i;
                  dat_reg <= wb_dat_i;
                  cnt_reg <= 4'(WAIT_STATES);
                  if (ZERO_WS) begin
                     state_reg <= ACK;
                     ack_reg   <= ~req_bad;
                     err_reg   <= req_bad;
                  end else begin
                     state_reg <= WAIT;
                  end
               end
            end
            WAIT: begin
               cnt_reg <= cnt_reg - 4'd1;
               if (!wb_cyc_i) begin
                  state_reg <= IDLE;
               end else if (cnt_reg == 4'd1) begin
                  state_reg <= ACK;
                  ack_reg   <= ~bad_reg;
                  err_reg   <= bad_reg;
               end
            end
            ACK:     state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   // One byte-wide RAM per lane keeps lane enables independent and each array single-driven.
   for (genvar gi = 0; gi < 4; gi++) begin : lane_g
      logic [7:0] mem_reg [DEPTH];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge wb_clk_i) begin
         if (wr_en && acc_sel[gi]) begin
            mem_reg[acc_idx] <= acc_dat[gi*8 +: 8];
         end
      end

      always_ff @(posedge wb_clk_i) begin
         if (wb_rst_i) begin
            rd_byte_reg <= 8'h00;
         end else if (rd_en) begin
            rd_byte_reg <= mem_reg[acc_idx];
         end
      end
   end

   assign wb_dat_o = {lane_g[3].rd_byte_reg, lane_g[2].rd_byte_reg,
                      lane_g[1].rd_byte_reg, lane_g[0].rd_byte_reg};
   assign wb_ack_o = ack_reg;
   assign wb_err_o = err_reg;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Randomized self-checking bench for wb_ram_slave against a word-array reference model.
// Build with WB_RAM_ERR_EN defined to exercise the error-acknowledge variant.
module tb_wb_ram_slave;

   localparam int AW = 12;
   localparam int WS = 1;
   localparam int NW = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic        ack;
   logic        err;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] mem_m [NW];
   logic [31:0] last_rd;

   always #5 clk = ~clk;

   wb_ram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst),
      .wb_cyc_i(cyc),
      .wb_stb_i(stb),
      .wb_we_i (we),
      .wb_adr_i(adr),
      .wb_sel_i(sel),
      .wb_dat_i(dat_w),
      .wb_dat_o(dat_r),
      .wb_ack_o(ack),
      .wb_err_o(err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One complete transfer; expected outcome comes from the model's address/lane rules.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      int idx = int'(a[7:2]);
      bit bad;
      int lat = 0;
`ifdef WB_RAM_ERR_EN
      bad = (a[1:0] != 2'b00) || (s == 4'b0000);
`else
      bad = 1'b0;
`endif
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (ack || err) begin
            lat = i;
            break;
         end
      end
      check_eq("latency", 32'(lat), 32'(WS + 1));
      check_eq("ack", 32'(ack), 32'(!bad));
      check_eq("err", 32'(err), 32'(bad));
      if (!bad) begin
         if (w) begin
            for (int b = 0; b < 4; b++) begin
               if (s[b]) mem_m[idx][b*8 +: 8] = d[b*8 +: 8];
            end
         end else begin
            last_rd = mem_m[idx];
         end
      end
      check_eq("rdata", dat_r, last_rd);
      $display("xfer we=%0d adr=%h sel=%h wdat=%h ack=%0d err=%0d rdat=%h", w, a, s, d, ack, err, dat_r);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      check_eq("pulse", {30'b0, ack, err}, 32'd0);
   endtask

   task automatic abort_xfer(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
      @(negedge clk);
      check_eq("abort_wait", {30'b0, ack, err}, 32'd0);
      cyc = 1'b0; stb = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("abort_noack", {30'b0, ack, err}, 32'd0);
      end
      check_eq("abort_rdata", dat_r, last_rd);
      $display("abort we=%0d adr=%h sel=%h wdat=%h rdat=%h", w, a, s, d, dat_r);
   endtask

   // Read held for two transfers with stb continuously high.
   task automatic back_to_back(input logic [31:0] a);
      int idx = int'(a[7:2]);
      bit exp_ack;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF; dat_w = 32'h0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         exp_ack = (i == 2) || (i == 5);
         check_eq("b2b_ack", 32'(ack), 32'(exp_ack));
         if (exp_ack) begin
            last_rd = mem_m[idx];
            check_eq("b2b_rdata", dat_r, last_rd);
            check_eq("b2b_const", dat_r, 32'hDEAD55EF);
         end
         if (i == 5) begin
            cyc = 1'b0; stb = 1'b0;
         end
      end
      $display("b2b adr=%h rdat=%h", a, dat_r);
   endtask

   // Reset lands on the edge that would commit the write: nothing is acked or written.
   task automatic reset_mid(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; sel = 4'hF; dat_w = d;
      @(negedge clk);
      rst = 1'b1; cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      last_rd = 32'h0;
      check_eq("rstmid_ack", {30'b0, ack, err}, 32'd0);
      check_eq("rstmid_dat", dat_r, last_rd);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_eq("rstmid_noack", {30'b0, ack, err}, 32'd0);
      end
      $display("reset_mid adr=%h wdat=%h", a, d);
   endtask

   initial begin
      logic [31:0] ra;
      logic [3:0]  rs;
      int          ri;
      rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; sel = 4'hF; dat_w = 32'h0;
      for (int i = 0; i < NW; i++) mem_m[i] = 32'h0;
      last_rd = 32'h0;

      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_eq("rst_ack", 32'(ack), 32'd0);
         check_eq("rst_err", 32'(err), 32'd0);
         check_eq("rst_dat", dat_r, 32'h0);
      end
      rst = 1'b0;
      // The held request is a write of zero to word 0, sampled on the first edge after release.
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk);
         check_eq("rst_release_ack", 32'(ack), 32'(i == 2));
      end
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      $display("reset done");

      for (int i = 1; i < NW; i++) xfer(1'b1, 32'(i * 4), 4'hF, 32'h0);

      xfer(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
      xfer(1'b0, 32'h10, 4'hF, 32'h0);
      check_eq("tp_write_read", dat_r, 32'hDEADBEEF);
      xfer(1'b1, 32'h10, 4'b0010, 32'h0000_5500);
      xfer(1'b0, 32'h10, 4'hF, 32'h0);
      check_eq("tp_byte_lane", dat_r, 32'hDEAD55EF);
      abort_xfer(1'b1, 32'h20, 4'hF, 32'h12345678);
      xfer(1'b0, 32'h20, 4'hF, 32'h0);
      check_eq("tp_abort", dat_r, 32'h0);
      back_to_back(32'h0000_4010);
      xfer(1'b1, 32'h11, 4'hF, 32'hCAFEF00D);
      xfer(1'b0, 32'h10, 4'hF, 32'h0);
      reset_mid(32'h14, 32'hA5A5A5A5);
      xfer(1'b0, 32'h14, 4'hF, 32'h0);

      for (int n = 0; n < 300; n++) begin
         ri = $urandom_range(0, 63);
         ra = ($urandom & 32'hFFFF_C000) | 32'(ri * 4);
         if ($urandom_range(0, 5) == 0) ra[1:0] = 2'($urandom_range(1, 3));
         rs = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            abort_xfer(1'($urandom), ra, rs, $urandom);
         end else begin
            xfer(1'($urandom), ra, rs, $urandom);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
